// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with guard blanking and frame-synchronous double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned GUARD   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic [3:0]  blank_i,
  input  logic        load_i,
  output logic        upd_pending,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [6:0]  seg7
);

  localparam int unsigned     CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   GUARD_C = CW'(GUARD);

  function automatic logic [6:0] hex_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [3:0]    act_blk_q, act_blk_d, pend_blk_q, pend_blk_d;
  logic          upd_pending_q, upd_pending_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg7_q, seg7_d;
  logic          boundary_s;
  logic [3:0]    digit_s;
  logic [3:0]    lzb_s;
  logic          dark_s;

  // Slot counter, digit index and frame-boundary buffer swap.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    act_val_d     = act_val_q;
    act_blk_d     = act_blk_q;
    pend_val_d    = pend_val_q;
    pend_blk_d    = pend_blk_q;
    upd_pending_d = upd_pending_q;
    boundary_s    = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (boundary_s) begin
      // A load landing on the boundary bypasses the pending buffer entirely.
      if (load_i) begin
        act_val_d = value_i;
        act_blk_d = blank_i;
      end else if (upd_pending_q) begin
        act_val_d = pend_val_q;
        act_blk_d = pend_blk_q;
      end else begin
        act_val_d = act_val_q;
        act_blk_d = act_blk_q;
      end
      upd_pending_d = 1'b0;
    end else if (load_i) begin
      pend_val_d    = value_i;
      pend_blk_d    = blank_i;
      upd_pending_d = 1'b1;
    end else begin
      upd_pending_d = upd_pending_q;
    end
    frame_done_d = (cnt_d == CNT_MAX) && (idx_d == 2'd3);
  end

  // Digit select, dark decision and pin values for the current slot position.
  always_comb begin
    case (idx_q)
      2'd0:    digit_s = act_val_q[3:0];
      2'd1:    digit_s = act_val_q[7:4];
      2'd2:    digit_s = act_val_q[11:8];
      2'd3:    digit_s = act_val_q[15:12];
      default: digit_s = act_val_q[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    lzb_s[3] = (act_val_q[15:12] == 4'h0);
    lzb_s[2] = lzb_s[3] && (act_val_q[11:8] == 4'h0);
    lzb_s[1] = lzb_s[2] && (act_val_q[7:4] == 4'h0);
    lzb_s[0] = 1'b0;
`else
    lzb_s = 4'b0000;
`endif
    dark_s = act_blk_q[idx_q] | lzb_s[idx_q];
    if ((cnt_q >= GUARD_C) && !dark_s) begin
      an_d   = ~(4'b0001 << idx_q);
      seg7_d = hex_decode(digit_s);
    end else begin
      an_d   = 4'b1111;
      seg7_d = 7'h7F;
    end
  end

  // State and output registers; reset aborts the frame and drops any pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      act_val_q     <= 16'h0000;
      act_blk_q     <= 4'b0000;
      pend_val_q    <= 16'h0000;
      pend_blk_q    <= 4'b0000;
      upd_pending_q <= 1'b0;
      frame_done_q  <= 1'b0;
      an_q          <= 4'b1111;
      seg7_q        <= 7'h7F;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_val_q     <= act_val_d;
      act_blk_q     <= act_blk_d;
      pend_val_q    <= pend_val_d;
      pend_blk_q    <= pend_blk_d;
      upd_pending_q <= upd_pending_d;
      frame_done_q  <= frame_done_d;
      an_q          <= an_d;
      seg7_q        <= seg7_d;
    end
  end

  assign upd_pending = upd_pending_q;
  assign frame_done  = frame_done_q;
  assign an          = an_q;
  assign seg7        = seg7_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (CLK_DIV=8, GUARD=2) against a positional reference model.
module tb_display_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = 16'h0000;
  logic [3:0]  blank_i = 4'b0000;
  logic        load_i = 1'b0;
  logic        upd_pending, frame_done;
  logic [3:0]  an;
  logic [6:0]  seg7;

  display_scan_ctrl #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .blank_i(blank_i), .load_i(load_i),
    .upd_pending(upd_pending), .frame_done(frame_done), .an(an), .seg7(seg7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: n = cycles since reset, so slot position is plain arithmetic on n.
  int          n;
  logic [15:0] act_v, pend_v;
  logic [3:0]  act_b, pend_b;
  bit          pend_f;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [10:0] show(input int pos, input logic [15:0] v, input logic [3:0] b);
    int         slot;
    int         c;
    logic [3:0] d;
    bit         dark;
    slot = (pos / CLK_DIV) % 4;
    c    = pos % CLK_DIV;
    d    = v[slot*4 +: 4];
    dark = b[slot];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (v >> (4 * slot)) == 16'h0000) dark = 1'b1;
`endif
    if (c < GUARD || dark) return {4'b1111, 7'h7F};
    return {~(4'b0001 << slot), seg_tab[d]};
  endfunction

  task automatic reset_model();
    n = 0; act_v = 16'h0000; act_b = 4'b0000; pend_f = 1'b0;
    exp_an = 4'b1111; exp_seg = 7'h7F;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      {exp_an, exp_seg} = show(n, act_v, act_b);
      if (n % FRAME == FRAME - 1) begin
        if (load_i) begin act_v = value_i; act_b = blank_i; end
        else if (pend_f) begin act_v = pend_v; act_b = pend_b; end
        pend_f = 1'b0;
      end else if (load_i) begin
        pend_v = value_i; pend_b = blank_i; pend_f = 1'b1;
      end
      n++;
    end
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] b);
    value_i = v; blank_i = b; load_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
    checks++; if (seg7 !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg7); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
    checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL reset_up got %b exp 0", upd_pending); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL first_guard_an got %b exp 1111", an); end
    tick();
    checks++; if (an !== 4'b1110 || seg7 !== 7'h40)
      begin errors++; $display("FAIL first_show got %b/%h exp 1110/40", an, seg7); end
  endtask

  task automatic test_free_run();
    int fd_cnt = 0;
    repeat (64) begin
      tick();
      if (frame_done === 1'b1) fd_cnt++;
      checks++; if (an !== exp_an || seg7 !== exp_seg)
        begin errors++; $display("FAIL free_pins n=%0d got %b/%h exp %b/%h", n, an, seg7, exp_an, exp_seg); end
      checks++; if (frame_done !== (n % FRAME == FRAME - 1))
        begin errors++; $display("FAIL free_fd n=%0d got %b", n, frame_done); end
    end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL free_fd_count got %0d exp 2", fd_cnt); end
  endtask

  task automatic test_load_midframe();
    logic [3:0] an_tab [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_exp [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    while (n % FRAME != 9) tick();
    load(16'h12AF, 4'b0000);
    checks++; if (upd_pending !== 1'b1) begin errors++; $display("FAIL mid_up_set got %b exp 1", upd_pending); end
    while (n % FRAME != 0) begin
      tick();
      checks++; if (upd_pending !== pend_f)
        begin errors++; $display("FAIL mid_up_hold n=%0d got %b exp %b", n, upd_pending, pend_f); end
    end
    checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL mid_up_clear got %b exp 0", upd_pending); end
    repeat (FRAME) begin
      tick();
      if (n % CLK_DIV == 3) begin
        checks++; if (an !== an_tab[(n / CLK_DIV) % 4] || seg7 !== seg_exp[(n / CLK_DIV) % 4])
          begin errors++; $display("FAIL mid_show n=%0d got %b/%h exp %b/%h", n, an, seg7,
                                   an_tab[(n / CLK_DIV) % 4], seg_exp[(n / CLK_DIV) % 4]); end
      end
    end
  endtask

  task automatic test_blank();
    while (n % FRAME != 12) tick();
    load(16'h12AF, 4'b0100);
    while (n % FRAME != 0) tick();
    repeat (FRAME) begin
      tick();
      checks++; if (an !== exp_an || seg7 !== exp_seg)
        begin errors++; $display("FAIL blank_pins n=%0d got %b/%h exp %b/%h", n, an, seg7, exp_an, exp_seg); end
      if (((n - 1) % FRAME) / CLK_DIV == 2) begin
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL blank_dark n=%0d got %b exp 1111", n, an); end
      end
    end
  endtask

  task automatic test_boundary_load();
    while (n % FRAME != FRAME - 1) tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bnd_fd got %b exp 1", frame_done); end
    load(16'h0003, 4'b0000);
    repeat (3) begin
      checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL bnd_up n=%0d got %b exp 0", n, upd_pending); end
      tick();
    end
    checks++; if (an !== 4'b1110 || seg7 !== 7'h30)
      begin errors++; $display("FAIL bnd_show got %b/%h exp 1110/30", an, seg7); end
  endtask

  task automatic test_random();
    repeat (700) begin
      if ($urandom_range(0, 5) == 0) begin
        value_i = 16'($urandom);
        if ($urandom_range(0, 1) == 0) value_i = value_i >> (4 * $urandom_range(1, 3));
        blank_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        load_i  = 1'b1;
      end
      tick();
      checks++; if (an !== exp_an || seg7 !== exp_seg)
        begin errors++; $display("FAIL rand_pins n=%0d got %b/%h exp %b/%h", n, an, seg7, exp_an, exp_seg); end
      checks++; if (upd_pending !== pend_f || frame_done !== (n % FRAME == FRAME - 1))
        begin errors++; $display("FAIL rand_flags n=%0d got up=%b fd=%b exp up=%b", n, upd_pending, frame_done, pend_f); end
    end
  endtask

  task automatic test_lzb_and_abort();
    while (n % FRAME != 5) tick();
    load(16'h0007, 4'b0000);
    while (n % FRAME != 0) tick();
    repeat (FRAME) begin
      tick();
      if (n % CLK_DIV == 3) begin
`ifdef LEADING_ZERO_BLANK_EN
        if (n / CLK_DIV % 4 == 0) begin
          checks++; if (an !== 4'b1110 || seg7 !== 7'h78)
            begin errors++; $display("FAIL lzb_d0 got %b/%h exp 1110/78", an, seg7); end
        end else begin
          checks++; if (an !== 4'b1111 || seg7 !== 7'h7F)
            begin errors++; $display("FAIL lzb_dark n=%0d got %b/%h exp 1111/7f", n, an, seg7); end
        end
`else
        checks++; if (seg7 !== ((n / CLK_DIV % 4 == 0) ? 7'h78 : 7'h40) || an === 4'b1111)
          begin errors++; $display("FAIL lzb_off n=%0d got %b/%h", n, an, seg7); end
`endif
      end
    end
    while (n % FRAME != 29) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (an !== 4'b1111 || seg7 !== 7'h7F)
      begin errors++; $display("FAIL abort_pins got %b/%h exp 1111/7f", an, seg7); end
    tick(); tick();
    checks++; if (frame_done !== 1'b0 || upd_pending !== 1'b0)
      begin errors++; $display("FAIL abort_flags got fd=%b up=%b exp 0/0", frame_done, upd_pending); end
    rst_n = 1'b1;
    repeat (40) begin
      tick();
      checks++; if (an !== exp_an || seg7 !== exp_seg || frame_done !== (n % FRAME == FRAME - 1))
        begin errors++; $display("FAIL post_abort n=%0d got %b/%h fd=%b exp %b/%h", n, an, seg7, frame_done, exp_an, exp_seg); end
    end
  endtask

  initial begin
    reset_model();
    @(negedge clk);
    test_reset();
    test_free_run();
    test_load_midframe();
    test_blank();
    test_boundary_load();
    test_random();
    test_lzb_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
